// File: rtl/bsg_manycore_host_mmio_responder.sv
// bsg_manycore_host_mmio_responder
//
// Purpose:
//   Host-side MMIO responder at the far end of the manycore IO link. It sits
//   behind an endpoint on the host coordinate and turns tile-originated EPA
//   requests into host services: finish, fail, print_stat, putchar, a cycle
//   timer and a scratch register. Every accepted request produces exactly one
//   response one cycle later.
//
// Address map (in_addr_i[3:0], upper bits ignored):
//   0x0 FINISH (W)        0x4 TIME (R)
//   0x1 FAIL (W)          0x5 SCRATCH (R/W)
//   0x2 PRINT_STAT (W)    0x6 FINISH_COUNT (R)
//   0x3 PUTCHAR (W)       0x7 SRC (R)
//   Any other offset is unmapped.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   in_v_i .. in_src_y_cord_i request from the endpoint
//   in_yumi_o                 request accepted this cycle
//   returning_v_o/_data_o     response, one cycle after accept
//   print_stat_v_o/_tag_o     head of the print_stat FIFO
//   print_stat_yumi_i         consumer dequeues the head
//   putchar_v_o/_data_o       one-cycle character pulse
//   finish_o, fail_o          sticky status for the testbench top
//   fail_code_o               data of the first FAIL write
//   finish_count_o            saturating count of FINISH writes
//   unmapped_err_o            sticky, any unmapped or illegal access

module bsg_manycore_host_mmio_responder #(
    parameter int                      data_width_p    = 32,
    parameter int                      addr_width_p    = 28,
    parameter int                      x_cord_width_p  = 7,
    parameter int                      y_cord_width_p  = 7,
    parameter int                      num_finish_p    = 16,
    parameter int                      stat_fifo_els_p = 2,
    parameter logic [data_width_p-1:0] err_data_p      = 32'hDEAD_BEEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        in_v_i,
    input  logic                        in_we_i,
    input  logic [addr_width_p-1:0]     in_addr_i,
    input  logic [data_width_p-1:0]     in_data_i,
    input  logic [data_width_p/8-1:0]   in_mask_i,
    input  logic [x_cord_width_p-1:0]   in_src_x_cord_i,
    input  logic [y_cord_width_p-1:0]   in_src_y_cord_i,
    output logic                        in_yumi_o,

    output logic                        returning_v_o,
    output logic [data_width_p-1:0]     returning_data_o,

    output logic                        print_stat_v_o,
    output logic [data_width_p-1:0]     print_stat_tag_o,
    input  logic                        print_stat_yumi_i,

    output logic                        putchar_v_o,
    output logic [7:0]                  putchar_data_o,

    output logic                        finish_o,
    output logic                        fail_o,
    output logic [data_width_p-1:0]     fail_code_o,
    output logic [15:0]                 finish_count_o,
    output logic                        unmapped_err_o
);

    typedef enum logic [3:0] {
        OFF_FINISH       = 4'h0,
        OFF_FAIL         = 4'h1,
        OFF_PRINT_STAT   = 4'h2,
        OFF_PUTCHAR      = 4'h3,
        OFF_TIME         = 4'h4,
        OFF_SCRATCH      = 4'h5,
        OFF_FINISH_COUNT = 4'h6,
        OFF_SRC          = 4'h7
    } offset_e;

    localparam int          ptr_width_lp   = (stat_fifo_els_p > 1) ? $clog2(stat_fifo_els_p) : 1;
    localparam int          cnt_width_lp   = ptr_width_lp + 1;
    localparam logic [15:0] num_finish_lp  = 16'(num_finish_p);

    // Only the low nibble of the address and mask bit 0 carry meaning here.
    logic unused_in_bits;
    assign unused_in_bits = ^{in_addr_i[addr_width_p-1:4], in_mask_i[data_width_p/8-1:1]};

    logic [3:0] offset;
    assign offset = in_addr_i[3:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                      ret_v_q,        ret_v_d;
    logic [data_width_p-1:0]   ret_data_q,     ret_data_d;
    logic [31:0]               cycle_q,        cycle_d;
    logic [data_width_p-1:0]   scratch_q,      scratch_d;
    logic [15:0]               finish_count_q, finish_count_d;
    logic                      finish_q,       finish_d;
    logic                      fail_q,         fail_d;
    logic [data_width_p-1:0]   fail_code_q,    fail_code_d;
    logic                      unmapped_q,     unmapped_d;
    logic                      putchar_v_q,    putchar_v_d;
    logic [7:0]                putchar_data_q, putchar_data_d;

    logic [data_width_p-1:0]   fifo_mem_q [stat_fifo_els_p];
    logic [data_width_p-1:0]   fifo_mem_d [stat_fifo_els_p];
    logic [ptr_width_lp-1:0]   fifo_wptr_q,    fifo_wptr_d;
    logic [ptr_width_lp-1:0]   fifo_rptr_q,    fifo_rptr_d;
    logic [cnt_width_lp-1:0]   fifo_count_q,   fifo_count_d;

    logic fifo_full;
    logic fifo_empty;
    logic stall;

    assign fifo_full  = (fifo_count_q == cnt_width_lp'(stat_fifo_els_p));
    assign fifo_empty = (fifo_count_q == '0);

    // Only a PRINT_STAT write against a full FIFO stalls. A same-cycle
    // dequeue is deliberately not allowed to relieve the stall, which keeps
    // in_yumi_o free of a combinational path from print_stat_yumi_i.
    assign stall     = in_we_i && (offset == OFF_PRINT_STAT) && fifo_full;
    assign in_yumi_o = in_v_i && !stall && !reset_i;

    // ------------------------------------------------------------------
    // Request decode, read mux and next-state computation
    // ------------------------------------------------------------------
    logic                    enq;
    logic                    deq;
    logic [data_width_p-1:0] rd_data;
    logic                    rd_err;
    logic                    wr_err;

    always_comb begin
        rd_data = err_data_p;
        rd_err  = 1'b0;
        wr_err  = 1'b0;

        // Read data is sampled at accept time, so a SCRATCH write followed by
        // a SCRATCH read on the next accept sees the registered new value.
        unique case (offset)
            OFF_TIME:         rd_data = data_width_p'(cycle_q);
            OFF_SCRATCH:      rd_data = scratch_q;
            OFF_FINISH_COUNT: rd_data = data_width_p'(finish_count_q);
            OFF_SRC:          rd_data = data_width_p'({in_src_y_cord_i, in_src_x_cord_i});
            default: begin
                rd_data = err_data_p;
                rd_err  = 1'b1;
            end
        endcase

        // Read-only and unmapped offsets ignore the write but still respond.
        unique case (offset)
            OFF_FINISH, OFF_FAIL, OFF_PRINT_STAT, OFF_PUTCHAR, OFF_SCRATCH: wr_err = 1'b0;
            default: wr_err = 1'b1;
        endcase
    end

    always_comb begin
        ret_v_d        = in_yumi_o;
        ret_data_d     = '0;
        cycle_d        = cycle_q + 32'd1;
        scratch_d      = scratch_q;
        finish_count_d = finish_count_q;
        finish_d       = finish_q;
        fail_d         = fail_q;
        fail_code_d    = fail_code_q;
        unmapped_d     = unmapped_q;
        putchar_v_d    = 1'b0;
        putchar_data_d = putchar_data_q;
        enq            = 1'b0;

        if (in_yumi_o) begin
            if (in_we_i) begin
                unmapped_d = unmapped_q | wr_err;
                unique case (offset)
                    OFF_FINISH: begin
                        if (finish_count_q != 16'hFFFF) begin
                            finish_count_d = finish_count_q + 16'd1;
                        end
                        finish_d = finish_q | (finish_count_d >= num_finish_lp);
                    end
                    OFF_FAIL: begin
                        if (!fail_q) begin
                            fail_d      = 1'b1;
                            fail_code_d = in_data_i;
                        end
                    end
                    OFF_PRINT_STAT: enq = 1'b1;
                    OFF_PUTCHAR: begin
                        if (in_mask_i[0]) begin
                            putchar_v_d    = 1'b1;
                            putchar_data_d = in_data_i[7:0];
                        end
                    end
                    OFF_SCRATCH: scratch_d = in_data_i;
                    default: ;
                endcase
            end else begin
                ret_data_d = rd_data;
                unmapped_d = unmapped_q | rd_err;
            end
        end
    end

    // print_stat FIFO: enqueue can only happen when not full because a full
    // FIFO stalls the request; dequeue on an empty FIFO is ignored.
    always_comb begin
        deq          = print_stat_yumi_i && !fifo_empty;
        fifo_mem_d   = fifo_mem_q;
        fifo_wptr_d  = fifo_wptr_q;
        fifo_rptr_d  = fifo_rptr_q;
        fifo_count_d = fifo_count_q;

        if (enq) begin
            fifo_mem_d[fifo_wptr_q] = in_data_i;
            fifo_wptr_d = (fifo_wptr_q == ptr_width_lp'(stat_fifo_els_p - 1))
                        ? '0 : fifo_wptr_q + ptr_width_lp'(1);
        end
        if (deq) begin
            fifo_rptr_d = (fifo_rptr_q == ptr_width_lp'(stat_fifo_els_p - 1))
                        ? '0 : fifo_rptr_q + ptr_width_lp'(1);
        end

        unique case ({enq, deq})
            2'b10:   fifo_count_d = fifo_count_q + cnt_width_lp'(1);
            2'b01:   fifo_count_d = fifo_count_q - cnt_width_lp'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset drops any pending response and empties the FIFO by
    // clearing its pointers; the storage itself needs no reset because the
    // head output is masked while empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ret_v_q        <= 1'b0;
            ret_data_q     <= '0;
            cycle_q        <= '0;
            scratch_q      <= '0;
            finish_count_q <= '0;
            finish_q       <= 1'b0;
            fail_q         <= 1'b0;
            fail_code_q    <= '0;
            unmapped_q     <= 1'b0;
            putchar_v_q    <= 1'b0;
            putchar_data_q <= '0;
            fifo_wptr_q    <= '0;
            fifo_rptr_q    <= '0;
            fifo_count_q   <= '0;
        end else begin
            ret_v_q        <= ret_v_d;
            ret_data_q     <= ret_data_d;
            cycle_q        <= cycle_d;
            scratch_q      <= scratch_d;
            finish_count_q <= finish_count_d;
            finish_q       <= finish_d;
            fail_q         <= fail_d;
            fail_code_q    <= fail_code_d;
            unmapped_q     <= unmapped_d;
            putchar_v_q    <= putchar_v_d;
            putchar_data_q <= putchar_data_d;
            fifo_wptr_q    <= fifo_wptr_d;
            fifo_rptr_q    <= fifo_rptr_d;
            fifo_count_q   <= fifo_count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign returning_v_o    = ret_v_q;
    assign returning_data_o = ret_data_q;
    assign print_stat_v_o   = !fifo_empty;
    assign print_stat_tag_o = fifo_empty ? '0 : fifo_mem_q[fifo_rptr_q];
    assign putchar_v_o      = putchar_v_q;
    assign putchar_data_o   = putchar_data_q;
    assign finish_o         = finish_q;
    assign fail_o           = fail_q;
    assign fail_code_o      = fail_code_q;
    assign finish_count_o   = finish_count_q;
    assign unmapped_err_o   = unmapped_q;

endmodule

// File: tb/tb_bsg_manycore_host_mmio_responder.sv
// tb_bsg_manycore_host_mmio_responder
//
// Purpose:
//   Directed, self-checking bench for bsg_manycore_host_mmio_responder.
//   Each scenario task drives requests and compares outputs against
//   hand-computed values. Inputs change 1ns after a rising edge and outputs
//   are sampled 1ns (registered) or 2ns (combinational accept) after it.

module tb_bsg_manycore_host_mmio_responder;

    logic        clk_i;
    logic        reset_i;
    logic        in_v_i;
    logic        in_we_i;
    logic [27:0] in_addr_i;
    logic [31:0] in_data_i;
    logic [3:0]  in_mask_i;
    logic [6:0]  in_src_x_cord_i;
    logic [6:0]  in_src_y_cord_i;
    logic        in_yumi_o;
    logic        returning_v_o;
    logic [31:0] returning_data_o;
    logic        print_stat_v_o;
    logic [31:0] print_stat_tag_o;
    logic        print_stat_yumi_i;
    logic        putchar_v_o;
    logic [7:0]  putchar_data_o;
    logic        finish_o;
    logic        fail_o;
    logic [31:0] fail_code_o;
    logic [15:0] finish_count_o;
    logic        unmapped_err_o;

    int checks;
    int failures;

    bsg_manycore_host_mmio_responder dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .in_v_i            (in_v_i),
        .in_we_i           (in_we_i),
        .in_addr_i         (in_addr_i),
        .in_data_i         (in_data_i),
        .in_mask_i         (in_mask_i),
        .in_src_x_cord_i   (in_src_x_cord_i),
        .in_src_y_cord_i   (in_src_y_cord_i),
        .in_yumi_o         (in_yumi_o),
        .returning_v_o     (returning_v_o),
        .returning_data_o  (returning_data_o),
        .print_stat_v_o    (print_stat_v_o),
        .print_stat_tag_o  (print_stat_tag_o),
        .print_stat_yumi_i (print_stat_yumi_i),
        .putchar_v_o       (putchar_v_o),
        .putchar_data_o    (putchar_data_o),
        .finish_o          (finish_o),
        .fail_o            (fail_o),
        .fail_code_o       (fail_code_o),
        .finish_count_o    (finish_count_o),
        .unmapped_err_o    (unmapped_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Advance to 1ns past the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and wait 1ns so the combinational accept settles.
    task automatic drive(input logic we, input logic [27:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [6:0] x, input logic [6:0] y);
        in_v_i          = 1'b1;
        in_we_i         = we;
        in_addr_i       = addr;
        in_data_i       = data;
        in_mask_i       = mask;
        in_src_x_cord_i = x;
        in_src_y_cord_i = y;
        #1;
    endtask

    task automatic idle();
        in_v_i    = 1'b0;
        in_we_i   = 1'b0;
        in_addr_i = '0;
        in_data_i = '0;
        in_mask_i = '0;
    endtask

    // Reset with a request presented: accept must stay low, every output 0.
    task automatic test_reset();
        reset_i = 1'b1;
        print_stat_yumi_i = 1'b0;
        idle();
        in_src_x_cord_i = '0;
        in_src_y_cord_i = '0;
        step();
        step();
        drive(1'b1, 28'h5, 32'hFFFF_FFFF, 4'hF, 7'd1, 7'd1);
        checks++;
        if (in_yumi_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_yumi: got %b, expected 0", in_yumi_o);
        end
        step();
        checks++;
        if ({returning_v_o, print_stat_v_o, putchar_v_o, finish_o, fail_o, unmapped_err_o} !== 6'b0 ||
            returning_data_o !== 32'h0 || print_stat_tag_o !== 32'h0 || fail_code_o !== 32'h0 ||
            finish_count_o !== 16'h0 || putchar_data_o !== 8'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got flags %b cnt %h code %h, expected all zero",
                     {returning_v_o, print_stat_v_o, putchar_v_o, finish_o, fail_o, unmapped_err_o},
                     finish_count_o, fail_code_o);
        end
        idle();
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_scratch();
        drive(1'b1, 28'h5, 32'h1234_5678, 4'hF, 7'd2, 7'd3);
        checks++;
        if (in_yumi_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scratch_wr_yumi: got %b, expected 1", in_yumi_o);
        end
        step();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL scratch_wr_resp: got v=%b d=%h, expected v=1 d=00000000",
                     returning_v_o, returning_data_o);
        end
        drive(1'b0, 28'hABC_DEF5, 32'h0, 4'hF, 7'd2, 7'd3);
        checks++;
        if (in_yumi_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scratch_rd_yumi: got %b, expected 1", in_yumi_o);
        end
        step();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'h1234_5678) begin
            failures++;
            $display("[TB] FAIL scratch_rd_resp: got v=%b d=%h, expected v=1 d=12345678",
                     returning_v_o, returning_data_o);
        end
        idle();
        step();
        checks++;
        if (returning_v_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resp_single: got v=%b, expected 0", returning_v_o);
        end
    endtask

    task automatic test_print_stat();
        drive(1'b1, 28'h2, 32'hA, 4'hF, 7'd0, 7'd0);
        checks++;
        if (in_yumi_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stat_a_yumi: got %b, expected 1", in_yumi_o);
        end
        step();
        drive(1'b1, 28'h2, 32'hB, 4'hF, 7'd0, 7'd0);
        checks++;
        if (in_yumi_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stat_b_yumi: got %b, expected 1", in_yumi_o);
        end
        step();
        drive(1'b1, 28'h2, 32'hC, 4'hF, 7'd0, 7'd0);
        checks++;
        if (in_yumi_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stat_c_stall: got %b, expected 0", in_yumi_o);
        end
        step();
        checks++;
        if (returning_v_o !== 1'b0 || print_stat_v_o !== 1'b1 || print_stat_tag_o !== 32'hA) begin
            failures++;
            $display("[TB] FAIL stat_head_a: got rv=%b v=%b tag=%h, expected rv=0 v=1 tag=0000000a",
                     returning_v_o, print_stat_v_o, print_stat_tag_o);
        end
        // Dequeue in the same cycle must not lift the stall.
        print_stat_yumi_i = 1'b1;
        #1;
        checks++;
        if (in_yumi_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stat_deq_stall: got %b, expected 0", in_yumi_o);
        end
        step();
        print_stat_yumi_i = 1'b0;
        #1;
        checks++;
        if (in_yumi_o !== 1'b1 || print_stat_tag_o !== 32'hB) begin
            failures++;
            $display("[TB] FAIL stat_c_accept: got yumi=%b tag=%h, expected yumi=1 tag=0000000b",
                     in_yumi_o, print_stat_tag_o);
        end
        step();
        idle();
        checks++;
        if (returning_v_o !== 1'b1 || print_stat_tag_o !== 32'hB) begin
            failures++;
            $display("[TB] FAIL stat_c_resp: got rv=%b tag=%h, expected rv=1 tag=0000000b",
                     returning_v_o, print_stat_tag_o);
        end
        print_stat_yumi_i = 1'b1;
        step();
        checks++;
        if (print_stat_v_o !== 1'b1 || print_stat_tag_o !== 32'hC) begin
            failures++;
            $display("[TB] FAIL stat_head_c: got v=%b tag=%h, expected v=1 tag=0000000c",
                     print_stat_v_o, print_stat_tag_o);
        end
        step();
        checks++;
        if (print_stat_v_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stat_empty: got v=%b, expected 0", print_stat_v_o);
        end
        // Dequeue while empty is ignored.
        step();
        print_stat_yumi_i = 1'b0;
        checks++;
        if (print_stat_v_o !== 1'b0 || print_stat_tag_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL stat_empty_deq: got v=%b tag=%h, expected v=0 tag=00000000",
                     print_stat_v_o, print_stat_tag_o);
        end
    endtask

    task automatic test_finish();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 28'h0, 32'h0, 4'hF, 7'(i), 7'(i + 1));
            step();
            if (i == 14) begin
                checks++;
                if (finish_o !== 1'b0 || finish_count_o !== 16'd15) begin
                    failures++;
                    $display("[TB] FAIL finish_early: got f=%b cnt=%0d, expected f=0 cnt=15",
                             finish_o, finish_count_o);
                end
            end
        end
        checks++;
        if (finish_o !== 1'b1 || finish_count_o !== 16'd16) begin
            failures++;
            $display("[TB] FAIL finish_rise: got f=%b cnt=%0d, expected f=1 cnt=16",
                     finish_o, finish_count_o);
        end
        drive(1'b0, 28'h6, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'd16) begin
            failures++;
            $display("[TB] FAIL finish_count_rd: got v=%b d=%h, expected v=1 d=00000010",
                     returning_v_o, returning_data_o);
        end
        drive(1'b1, 28'h0, 32'h0, 4'hF, 7'd9, 7'd9);
        step();
        idle();
        checks++;
        if (finish_o !== 1'b1 || finish_count_o !== 16'd17) begin
            failures++;
            $display("[TB] FAIL finish_17: got f=%b cnt=%0d, expected f=1 cnt=17",
                     finish_o, finish_count_o);
        end
        drive(1'b0, 28'h7, 32'h0, 4'hF, 7'h15, 7'h2A);
        step();
        idle();
        checks++;
        if (returning_data_o !== 32'h0000_1515) begin
            failures++;
            $display("[TB] FAIL src_rd: got %h, expected 00001515", returning_data_o);
        end
    endtask

    task automatic test_fail();
        drive(1'b1, 28'h1, 32'h55, 4'hF, 7'd0, 7'd0);
        step();
        checks++;
        if (fail_o !== 1'b1 || fail_code_o !== 32'h55) begin
            failures++;
            $display("[TB] FAIL fail_first: got f=%b code=%h, expected f=1 code=00000055",
                     fail_o, fail_code_o);
        end
        drive(1'b1, 28'h1, 32'h66, 4'hF, 7'd0, 7'd0);
        step();
        idle();
        checks++;
        if (fail_o !== 1'b1 || fail_code_o !== 32'h55 || unmapped_err_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fail_second: got f=%b code=%h err=%b, expected f=1 code=00000055 err=0",
                     fail_o, fail_code_o, unmapped_err_o);
        end
    endtask

    task automatic test_putchar();
        drive(1'b1, 28'h3, 32'h42, 4'hE, 7'd0, 7'd0);
        step();
        checks++;
        if (putchar_v_o !== 1'b0 || returning_v_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL putchar_nomask: got pc=%b rv=%b, expected pc=0 rv=1",
                     putchar_v_o, returning_v_o);
        end
        drive(1'b1, 28'h3, 32'h7741, 4'h1, 7'd0, 7'd0);
        step();
        idle();
        checks++;
        if (putchar_v_o !== 1'b1 || putchar_data_o !== 8'h41) begin
            failures++;
            $display("[TB] FAIL putchar_pulse: got v=%b d=%h, expected v=1 d=41",
                     putchar_v_o, putchar_data_o);
        end
        step();
        checks++;
        if (putchar_v_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL putchar_one_cycle: got %b, expected 0", putchar_v_o);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] t1;
        logic [31:0] t2;
        drive(1'b0, 28'h9, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'hDEAD_BEEF || unmapped_err_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL unmapped_rd: got v=%b d=%h err=%b, expected v=1 d=deadbeef err=1",
                     returning_v_o, returning_data_o, unmapped_err_o);
        end
        drive(1'b0, 28'h3, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        checks++;
        if (returning_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL wo_rd: got %h, expected deadbeef", returning_data_o);
        end
        drive(1'b1, 28'h4, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL time_wr_resp: got v=%b d=%h, expected v=1 d=00000000",
                     returning_v_o, returning_data_o);
        end
        drive(1'b0, 28'h4, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        idle();
        t1 = returning_data_o;
        for (int i = 0; i < 9; i++) step();
        drive(1'b0, 28'h4, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        idle();
        t2 = returning_data_o;
        checks++;
        if (t2 - t1 !== 32'd10 || t1 === 32'h0) begin
            failures++;
            $display("[TB] FAIL time_delta: got t1=%h t2=%h diff=%0d, expected diff=10 t1 nonzero",
                     t1, t2, t2 - t1);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 28'h2, 32'h11, 4'hF, 7'd0, 7'd0);
        step();
        drive(1'b1, 28'h2, 32'h22, 4'hF, 7'd0, 7'd0);
        step();
        drive(1'b1, 28'h3, 32'h41, 4'h1, 7'd0, 7'd0);
        step();
        checks++;
        if (returning_v_o !== 1'b1 || putchar_v_o !== 1'b1 || print_stat_tag_o !== 32'h11) begin
            failures++;
            $display("[TB] FAIL pre_reset: got rv=%b pc=%b tag=%h, expected rv=1 pc=1 tag=00000011",
                     returning_v_o, putchar_v_o, print_stat_tag_o);
        end
        reset_i = 1'b1;
        drive(1'b1, 28'h5, 32'h99, 4'hF, 7'd0, 7'd0);
        checks++;
        if (in_yumi_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_yumi: got %b, expected 0", in_yumi_o);
        end
        step();
        checks++;
        if ({returning_v_o, print_stat_v_o, putchar_v_o, finish_o, fail_o, unmapped_err_o} !== 6'b0 ||
            finish_count_o !== 16'h0 || fail_code_o !== 32'h0 || print_stat_tag_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_state: got flags %b cnt %h code %h, expected all zero",
                     {returning_v_o, print_stat_v_o, putchar_v_o, finish_o, fail_o, unmapped_err_o},
                     finish_count_o, fail_code_o);
        end
        reset_i = 1'b0;
        idle();
        step();
        drive(1'b0, 28'h5, 32'h0, 4'hF, 7'd0, 7'd0);
        step();
        idle();
        checks++;
        if (returning_v_o !== 1'b1 || returning_data_o !== 32'h0) begin
            failures++;
            $display("[TB] FAIL scratch_after_reset: got v=%b d=%h, expected v=1 d=00000000",
                     returning_v_o, returning_data_o);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_scratch();
        test_print_stat();
        test_finish();
        test_fail();
        test_putchar();
        test_unmapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
